// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// State encodings are fixed so that waveform decoders and debug tools can rely on them.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 255;

    // Smallest counter width that can hold TIMEOUT-1 (at least one bit).
    function automatic int ctr_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_bus_timeout_ctr.sv
// Wait-cycle counter for one memory transaction; expired flags the cycle the count equals limit.
// Latency: combinational expired from registered count; no backpressure.
module bus_timeout_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CW      = ctr_width(TIMEOUT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] limit,
    output logic          expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign expired = en && (cnt == limit);
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between fetch and load/store, one registered transaction at a time.
// Latency: 2 cycles request-to-ready minimum; stall_pipe holds requesters until their ready pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              stall_pipe,
    output logic              bus_err,
    output logic              err_sticky
);

    localparam int CW = ctr_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t state;
    logic       last_was_data;
    logic       data_pend;
    logic       timed_out;

    assign data_pend  = mem_read | mem_write;
    assign stall_pipe = (if_req & ~if_ready) | (data_pend & ~d_ready);

    bus_timeout_ctr #(.TIMEOUT(TIMEOUT), .CW(CW)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == IDLE),
        .en      (m_req & ~m_ack),
        .limit   (LIMIT),
        .expired (timed_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_was_data <= 1'b0;
            m_req         <= 1'b0;
            m_we          <= 1'b0;
            m_addr        <= '0;
            m_wdata       <= '0;
            if_rdata      <= '0;
            d_rdata       <= '0;
            if_ready      <= 1'b0;
            d_ready       <= 1'b0;
            bus_err       <= 1'b0;
            err_sticky    <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // Data normally wins; a fetch waiting behind a data access goes next.
                    if (if_req && (!data_pend || last_was_data)) begin
                        state   <= FETCH;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                        m_wdata <= '0;
                    end else if (data_pend) begin
                        state   <= DATA;
                        m_req   <= 1'b1;
                        m_we    <= mem_write;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                    end
                end
                FETCH, DATA: begin
                    if (m_ack || timed_out) begin
                        state   <= IDLE;
                        m_req   <= 1'b0;
                        bus_err <= ~m_ack;
                        if (!m_ack) begin
                            err_sticky <= 1'b1;
                        end
                        if (state == FETCH) begin
                            if_ready      <= 1'b1;
                            if_rdata      <= m_ack ? m_rdata : '0;
                            last_was_data <= 1'b0;
                        end else begin
                            d_ready       <= 1'b1;
                            d_rdata       <= (m_ack && !m_we) ? m_rdata : '0;
                            last_was_data <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: default-timeout instance for normal traffic,
// a TIMEOUT=4 instance for the forced-completion path.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        if_req, mem_read, mem_write, m_ack;
    logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_ready, d_ready, m_req, m_we, stall_pipe, bus_err, err_sticky;

    logic        t_if_req, t_mem_read, t_mem_write, t_m_ack;
    logic [31:0] t_if_addr, t_d_addr, t_d_wdata, t_m_rdata;
    logic [31:0] t_if_rdata, t_d_rdata, t_m_addr, t_m_wdata;
    logic        t_if_ready, t_d_ready, t_m_req, t_m_we, t_stall_pipe, t_bus_err, t_err_sticky;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_read(mem_read), .mem_write(mem_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .stall_pipe(stall_pipe), .bus_err(bus_err), .err_sticky(err_sticky)
    );

    mem_port_arbiter #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst),
        .if_req(t_if_req), .if_addr(t_if_addr), .if_rdata(t_if_rdata), .if_ready(t_if_ready),
        .mem_read(t_mem_read), .mem_write(t_mem_write), .d_addr(t_d_addr), .d_wdata(t_d_wdata),
        .d_rdata(t_d_rdata), .d_ready(t_d_ready),
        .m_req(t_m_req), .m_we(t_m_we), .m_addr(t_m_addr), .m_wdata(t_m_wdata),
        .m_rdata(t_m_rdata), .m_ack(t_m_ack),
        .stall_pipe(t_stall_pipe), .bus_err(t_bus_err), .err_sticky(t_err_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {if_req, mem_read, mem_write, m_ack} = '0;
        {if_addr, d_addr, d_wdata, m_rdata} = '0;
        {t_if_req, t_mem_read, t_mem_write, t_m_ack} = '0;
        {t_if_addr, t_d_addr, t_d_wdata, t_m_rdata} = '0;
        #12;
        chk("rst_m_req", m_req, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_stall", stall_pipe, 0);
        #10 rst = 1'b0;
        tick();

        // Fetch only, zero-wait memory; ack high in IDLE must be ignored.
        m_ack = 1'b1; m_rdata = 32'h8C010004;
        tick();
        chk("t1_idle_ack_ignored", {if_ready, m_req}, 0);
        if_req = 1'b1; if_addr = 32'h40;
        #1 chk("t1_stall_c0", stall_pipe, 1);
        tick();
        chk("t1_m_req", m_req, 1);
        chk("t1_m_addr", m_addr, 32'h40);
        chk("t1_m_we", m_we, 0);
        chk("t1_if_ready_early", if_ready, 0);
        chk("t1_stall_c1", stall_pipe, 1);
        tick();
        chk("t1_if_ready", if_ready, 1);
        chk("t1_if_rdata", if_rdata, 32'h8C010004);
        chk("t1_m_req_drop", m_req, 0);
        chk("t1_stall_off", stall_pipe, 0);
        if_req = 1'b0;
        tick();
        chk("t1_if_ready_pulse", if_ready, 0);

        // Fetch and store together: store first, then fetch beats a second data request.
        if_req = 1'b1; if_addr = 32'h44;
        mem_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; m_rdata = 32'h11112222;
        tick();
        chk("t2_m_we", m_we, 1);
        chk("t2_m_addr", m_addr, 32'h100);
        chk("t2_m_wdata", m_wdata, 32'hDEADBEEF);
        tick();
        chk("t2_d_ready", d_ready, 1);
        chk("t2_store_rdata", d_rdata, 0);
        mem_write = 1'b0; mem_read = 1'b1; d_addr = 32'h200;
        tick();
        chk("t2_fetch_wins_addr", m_addr, 32'h44);
        chk("t2_fetch_wins_we", m_we, 0);
        tick();
        chk("t2_if_ready", if_ready, 1);
        chk("t2_if_rdata", if_rdata, 32'h11112222);
        chk("t2_d_still_stalled", stall_pipe, 1);
        if_req = 1'b0;
        tick();
        chk("t2_load_addr", m_addr, 32'h200);
        chk("t2_load_req", m_req, 1);
        tick();
        chk("t2_d_ready_load", d_ready, 1);
        chk("t2_load_rdata", d_rdata, 32'h11112222);
        mem_read = 1'b0;
        tick();

        // Load with acknowledge delayed to the fifth request cycle.
        m_ack = 1'b0; mem_read = 1'b1; d_addr = 32'h300; m_rdata = 32'hCAFE0003;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_m_req_held", m_req, 1);
            chk("t3_m_addr_stable", m_addr, 32'h300);
            chk("t3_stall_held", stall_pipe, 1);
            chk("t3_no_ready", d_ready, 0);
            if (i == 4) m_ack = 1'b1;
            tick();
        end
        chk("t3_d_ready", d_ready, 1);
        chk("t3_d_rdata", d_rdata, 32'hCAFE0003);
        chk("t3_no_err", bus_err, 0);
        mem_read = 1'b0;
        tick();

        // Read and write both high: one write, no load data returned.
        mem_read = 1'b1; mem_write = 1'b1; d_addr = 32'h180; d_wdata = 32'h5555AAAA;
        tick();
        chk("t6_m_we", m_we, 1);
        chk("t6_m_wdata", m_wdata, 32'h5555AAAA);
        tick();
        chk("t6_d_ready", d_ready, 1);
        chk("t6_d_rdata", d_rdata, 0);
        mem_read = 1'b0; mem_write = 1'b0;
        tick();
        chk("t6_single_txn", m_req, 0);

        // TIMEOUT=4 instance, acknowledge never arrives.
        t_if_req = 1'b1; t_if_addr = 32'h80; t_m_rdata = 32'hFFFF0000;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t4_m_req", t_m_req, 1);
            chk("t4_no_ready", t_if_ready, 0);
            chk("t4_no_err", t_bus_err, 0);
            tick();
        end
        chk("t4_if_ready", t_if_ready, 1);
        chk("t4_if_rdata", t_if_rdata, 0);
        chk("t4_bus_err", t_bus_err, 1);
        chk("t4_sticky", t_err_sticky, 1);
        chk("t4_m_req_drop", t_m_req, 0);
        t_if_req = 1'b0;
        tick();
        chk("t4_bus_err_pulse", t_bus_err, 0);
        chk("t4_sticky_hold", t_err_sticky, 1);
        t_mem_read = 1'b1; t_d_addr = 32'h90; t_m_ack = 1'b1; t_m_rdata = 32'h00001234;
        tick();
        tick();
        chk("t4_next_ready", t_d_ready, 1);
        chk("t4_next_rdata", t_d_rdata, 32'h00001234);
        chk("t4_next_no_err", t_bus_err, 0);
        chk("t4_next_sticky", t_err_sticky, 1);
        t_mem_read = 1'b0; t_m_ack = 1'b0;
        tick();

        // Reset while a load is waiting for its acknowledge.
        m_ack = 1'b0; mem_read = 1'b1; d_addr = 32'h400;
        tick();
        chk("t5_waiting", m_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_m_req_async", m_req, 0);
        chk("t5_m_addr", m_addr, 0);
        chk("t5_d_ready", d_ready, 0);
        chk("t5_t_sticky_cleared", t_err_sticky, 0);
        mem_read = 1'b0; if_req = 1'b1; if_addr = 32'h60;
        m_ack = 1'b1; m_rdata = 32'h0BADF00D;
        #2 rst = 1'b0;
        tick();
        chk("t5_fetch_granted", m_req, 1);
        chk("t5_fetch_addr", m_addr, 32'h60);
        tick();
        chk("t5_if_ready", if_ready, 1);
        chk("t5_if_rdata", if_rdata, 32'h0BADF00D);
        if_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
